// File: rtl/booth_r4_seq_encoder.sv
// Sequential radix-4 Booth multiplier front end: emits one Booth select code per
// digit and accumulates the sign-extended, shifted partial products into a 2N-bit product.
module booth_r4_seq_encoder #(
    parameter int N = 8,
    localparam int SW = ($clog2(N / 2) < 1) ? 1 : $clog2(N / 2)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           busy,
    output logic [2:0]     sel,
    output logic [SW-1:0]  step,
    output logic           done,
    output logic [2*N-1:0] product
);

    // FLUSH lets the last registered partial product drain into the sum.
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t         state, state_next;
    logic [N-1:0]   mcand;
    logic [N:0]     sreg;
    logic [SW-1:0]  step_q;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] pp_q;
    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] pp_shift;
    logic [2:0]     sel_enc;

    // Booth digit from the registered triplet {b[2i+1], b[2i], b[2i-1]}.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        sel_enc = 3'b000;
        unique case (sreg[2:0])
            3'b001, 3'b010: sel_enc = 3'b001;
            3'b011:         sel_enc = 3'b010;
            3'b100:         sel_enc = 3'b110;
            3'b101, 3'b110: sel_enc = 3'b101;
            default:        sel_enc = 3'b000;
        endcase
    end

    // Sign-extend before negating or doubling so -2A of the most negative operand cannot overflow.
    always_comb begin
        a_ext = {{N{mcand[N-1]}}, mcand};
        pp    = '0;
        unique case (sel_enc)
            3'b001:  pp = a_ext;
            3'b010:  pp = a_ext << 1;
            3'b110:  pp = -(a_ext << 1);
            3'b101:  pp = -a_ext;
            default: pp = '0;
        endcase
        pp_shift = pp << {step_q, 1'b0};
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (step_q == SW'(N / 2 - 1)) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            mcand   <= '0;
            sreg    <= '0;
            step_q  <= '0;
            acc     <= '0;
            pp_q    <= '0;
            product <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    mcand  <= multiplicand;
                    sreg   <= {multiplier, 1'b0};
                    step_q <= '0;
                    acc    <= '0;
                    pp_q   <= '0;
                end
                RUN: begin
                    pp_q   <= pp_shift;
                    acc    <= acc + pp_q;
                    sreg   <= {{2{sreg[N]}}, sreg[N:2]};
                    step_q <= step_q + SW'(1);
                end
                FLUSH: begin
                    acc     <= acc + pp_q;
                    product <= acc + pp_q;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == FLUSH);
    assign done = (state == DONE);
    assign sel  = (state == RUN) ? sel_enc : 3'b000;
    assign step = (state == RUN) ? step_q : '0;

endmodule

// File: tb/tb_booth_r4_seq_encoder.sv
// Directed and randomised bench for booth_r4_seq_encoder at N=8 with a signed A*B reference.
module tb_booth_r4_seq_encoder;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        busy;
    logic [2:0]  sel;
    logic [1:0]  step;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int failures = 0;

    booth_r4_seq_encoder #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .sel(sel), .step(step), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic sel_legal(input logic [2:0] s);
        return (s == 3'b000) || (s == 3'b001) || (s == 3'b010) || (s == 3'b101) || (s == 3'b110);
    endfunction

    // Waits for done, expecting it at negedge number exp_cyc counted from the accept edge.
    task automatic wait_done(input int cyc0, input int exp_cyc, input logic [15:0] exp_p);
        int  cyc;
        bit  seen;
        cyc  = cyc0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else check("busy_before_done", busy, 1'b1);
        end
        check("done_seen", seen, 1'b1);
        check("latency", cyc, exp_cyc);
        check("product", product, exp_p);
        check("busy_in_done", busy, 1'b0);
        check("sel_in_done", sel, 3'b000);
    endtask

    task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic [15:0] exp_p,
                         input logic [11:0] exp_sels, input bit chk_sel, input bit chk_pulse);
        @(negedge clk);
        multiplicand = op_a;
        multiplier   = op_b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = ~op_a;
        multiplier   = ~op_b;
        for (int i = 0; i < N / 2; i++) begin
            @(negedge clk);
            check("busy_run", busy, 1'b1);
            check("step_run", step, i);
            check("sel_legal", sel_legal(sel), 1'b1);
            check("done_run", done, 1'b0);
            if (chk_sel) check($sformatf("sel_step%0d", i), sel, exp_sels[3*i +: 3]);
        end
        wait_done(N / 2, 6, exp_p);
        if (chk_pulse) begin
            @(negedge clk);
            check("done_pulse_end", done, 1'b0);
            check("product_hold", product, exp_p);
        end
    endtask

    initial begin
        logic [7:0]  ra, rb;
        logic [15:0] rp;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_sel", sel, 3'b000);
        check("rst_step", step, 2'd0);
        check("rst_done", done, 1'b0);
        check("rst_product", product, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 1'b0);

        do_op(8'd7, 8'd3, 16'h0015, {3'b000, 3'b000, 3'b001, 3'b101}, 1'b1, 1'b1);
        do_op(8'h80, 8'h80, 16'h4000, {3'b110, 3'b000, 3'b000, 3'b000}, 1'b1, 1'b1);
        do_op(8'h80, 8'h7F, 16'hC080, {3'b010, 3'b000, 3'b000, 3'b101}, 1'b1, 1'b1);
        do_op(8'h5A, 8'h00, 16'h0000, {3'b000, 3'b000, 3'b000, 3'b000}, 1'b1, 1'b1);
        do_op(8'h00, 8'hFF, 16'h0000, {3'b000, 3'b000, 3'b000, 3'b101}, 1'b1, 1'b1);

        // start held high through RUN and DONE with changing operands.
        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd3;
        start        = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N / 2; i++) begin
            multiplicand = 8'(20 + i);
            multiplier   = 8'(100 - i);
            @(negedge clk);
            check("hold_step", step, i);
            check("hold_sel", sel, (i == 0) ? 3'b101 : ((i == 1) ? 3'b001 : 3'b000));
            check("hold_done_run", done, 1'b0);
        end
        multiplicand = 8'd5;
        multiplier   = 8'hFD;
        wait_done(N / 2, 6, 16'h0015);
        @(negedge clk);
        check("hold_idle_busy", busy, 1'b0);
        check("hold_idle_done", done, 1'b0);
        @(negedge clk);
        check("hold_accept_busy", busy, 1'b1);
        start        = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 8'h00;
        wait_done(1, 6, 16'hFFF1);

        // Reset asserted during step 2 of an operation.
        @(negedge clk);
        multiplicand = 8'd9;
        multiplier   = 8'd11;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_step", step, 2'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_sel", sel, 3'b000);
        check("mid_rst_step", step, 2'd0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_product", product, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_done", done, 1'b0);
        end
        rst_n = 1'b1;
        do_op(8'd9, 8'd11, 16'd99, 12'h000, 1'b0, 1'b1);
        do_op(8'hF6, 8'd12, 16'hFF88, 12'h000, 1'b0, 1'b0);

        for (int k = 0; k < 4000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rp = 16'($signed(ra) * $signed(rb));
            do_op(ra, rb, rp, 12'h000, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
